// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light controller.
//   LAMP_*     : lamp encodings {red,yellow,green}, always one-hot
//   tl_state_e : controller state; StWalk exists only when TL_PED_WALK_EN is defined
package tl_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        StAGreen  = 3'd0,
        StAYellow = 3'd1,
        StAllRedA = 3'd2,
        StBGreen  = 3'd3,
        StBYellow = 3'd4,
`ifdef TL_PED_WALK_EN
        StAllRedB = 3'd5,
        StWalk    = 3'd6
`else
        StAllRedB = 3'd5
`endif
    } tl_state_e;

endpackage

// File: rtl/tick_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for the divided tick input.
// The raw input is treated purely as data.
//   clock_in : system clock
//   reset    : asynchronous active-low reset
//   d        : raw asynchronous input
//   pulse    : one-cycle pulse per synchronised 0->1 edge
module tick_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller; road A is the main road and keeps green
// until road B has a car waiting. Phase lengths are counted in tick pulses.
// Optional pedestrian walk phase enabled by defining TL_PED_WALK_EN.
//   clock_in : system clock
//   reset    : asynchronous active-low reset
//   tick_in  : asynchronous divided square wave, one tick per rising edge
//   sa, sb   : car-present sensors, road A / road B (sa is unused)
//   ped_req  : pedestrian button (ignored unless TL_PED_WALK_EN)
//   la, lb   : road lamps {red,yellow,green}
//   walk     : pedestrian walk lamp
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 4
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       sa,
    input  logic       sb,
    input  logic       ped_req,
    output logic [2:0] la,
    output logic [2:0] lb,
    output logic       walk
);

    localparam logic [7:0] G_LAST  = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] Y_LAST  = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] AR_LAST = 8'(ALLRED_TICKS - 1);
    localparam logic [7:0] W_LAST  = 8'(WALK_TICKS - 1);

    logic       tick;
    tl_state_e  state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] phase_last;
    logic       expired;

    // Road A has priority; its sensor carries no information for the FSM.
    logic unused_sa;
    assign unused_sa = sa;

    tick_edge_detect u_tick_edge_detect (
        .clock_in (clock_in),
        .reset    (reset),
        .d        (tick_in),
        .pulse    (tick)
    );

    function automatic logic [2:0] lamp_a(input tl_state_e s);
        case (s)
            StAGreen:  return LAMP_GREEN;
            StAYellow: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input tl_state_e s);
        case (s)
            StBGreen:  return LAMP_GREEN;
            StBYellow: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

`ifdef TL_PED_WALK_EN
    logic ped_pending_q, ped_pending_d;
    logic next_green_q, next_green_d;   // 1: resume with B_GREEN after walk
    logic walk_q;
    assign walk = walk_q;
`else
    logic       unused_ped_req;
    logic [7:0] unused_w_last;
    assign unused_ped_req = ped_req;
    assign unused_w_last  = W_LAST;
    assign walk           = 1'b0;
`endif

    always_comb begin
        case (state_q)
            StAGreen, StBGreen:   phase_last = G_LAST;
            StAYellow, StBYellow: phase_last = Y_LAST;
`ifdef TL_PED_WALK_EN
            StWalk:               phase_last = W_LAST;
`endif
            default:              phase_last = AR_LAST;
        endcase

        expired = tick && (timer_q == phase_last);
        state_d = state_q;
        timer_d = tick ? timer_q + 8'd1 : timer_q;
`ifdef TL_PED_WALK_EN
        next_green_d = next_green_q;
`endif

        case (state_q)
            StAGreen: begin
                if (expired) begin
                    if (sb) state_d = StAYellow;
                    else    timer_d = timer_q;   // saturate, wait for a B car
                end
            end
            StAYellow: if (expired) state_d = StAllRedA;
            StAllRedA: begin
                if (expired) begin
                    state_d = StBGreen;
`ifdef TL_PED_WALK_EN
                    if (ped_pending_q) begin
                        state_d      = StWalk;
                        next_green_d = 1'b1;
                    end
`endif
                end
            end
            // B releases early once it has had at least one tick and is empty.
            StBGreen: begin
                if (expired || (tick && timer_q != 8'd0 && !sb)) state_d = StBYellow;
            end
            StBYellow: if (expired) state_d = StAllRedB;
            StAllRedB: begin
                if (expired) begin
                    state_d = StAGreen;
`ifdef TL_PED_WALK_EN
                    if (ped_pending_q) begin
                        state_d      = StWalk;
                        next_green_d = 1'b0;
                    end
`endif
                end
            end
`ifdef TL_PED_WALK_EN
            StWalk: if (expired) state_d = next_green_q ? StBGreen : StAGreen;
`endif
            default: state_d = StAllRedB;
        endcase

        if (state_d != state_q) timer_d = 8'd0;

`ifdef TL_PED_WALK_EN
        // A request in the entry cycle survives the clear.
        ped_pending_d = ped_pending_q | ped_req;
        if (state_d == StWalk && state_q != StWalk) ped_pending_d = ped_req;
`endif
    end

    // Lamps are registered from the next state so they always match state_q.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q <= StAllRedB;
            timer_q <= 8'd0;
            la      <= LAMP_RED;
            lb      <= LAMP_RED;
`ifdef TL_PED_WALK_EN
            ped_pending_q <= 1'b0;
            next_green_q  <= 1'b0;
            walk_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            la      <= lamp_a(state_d);
            lb      <= lamp_b(state_d);
`ifdef TL_PED_WALK_EN
            ped_pending_q <= ped_pending_d;
            next_green_q  <= next_green_d;
            walk_q        <= (state_d == StWalk);
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with default parameters.
module tb_traffic_light_fsm;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       sa;
    logic       sb;
    logic       ped_req;
    logic [2:0] la;
    logic [2:0] lb;
    logic       walk;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clock_in (clk),
        .reset    (reset),
        .tick_in  (tick_in),
        .sa       (sa),
        .sb       (sb),
        .ped_req  (ped_req),
        .la       (la),
        .lb       (lb),
        .walk     (walk)
    );

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {la,lb,walk}=%b expected %b", tag, got, exp);
        end
    endtask

    // Raw edge at N0; FSM acts on the 3rd rising edge; returns well settled.
    task automatic do_tick();
        @(negedge clk);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Same as do_tick but checks lamps just before and just after the acting edge.
    task automatic tick_latency(input string tag, input logic [6:0] pre, input logic [6:0] post);
        @(negedge clk);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        check({tag, "_pre"}, {la, lb, walk}, pre);
        @(negedge clk);
        check({tag, "_post"}, {la, lb, walk}, post);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_phase(input string tag, input int n, input logic [2:0] ea,
                             input logic [2:0] eb, input logic ew);
        for (int i = 0; i < n; i++) begin
            check(tag, {la, lb, walk}, {ea, eb, ew});
            do_tick();
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        tick_in = 1'b0;
        sa      = 1'b0;
        sb      = 1'b0;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vals", {la, lb, walk}, {R, R, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        check("post_release", {la, lb, walk}, {R, R, 1'b0});

        // No B traffic: A goes green after one all-red tick and stays there.
        sa = 1'b1;
        tick_latency("first_tick", {R, R, 1'b0}, {G, R, 1'b0});
        for (int i = 0; i < 19; i++) begin
            do_tick();
            check("a_hold", {la, lb, walk}, {G, R, 1'b0});
        end
        // Timer has saturated, so a B car releases A on the very next tick.
        sb = 1'b1;
        do_tick();
        check("sat_release", {la, lb, walk}, {Y, R, 1'b0});

        // Full cycle with B traffic held.
        apply_reset();
        sa = 1'b0;
        run_phase("allred_b0", 1, R, R, 1'b0);
        run_phase("a_green", 5, G, R, 1'b0);
        run_phase("a_yellow", 2, Y, R, 1'b0);
        run_phase("allred_a", 1, R, R, 1'b0);
        run_phase("b_green", 5, R, G, 1'b0);
        run_phase("b_yellow", 2, R, Y, 1'b0);
        run_phase("allred_b", 1, R, R, 1'b0);
        run_phase("a_green2", 5, G, R, 1'b0);
        check("a_yellow2", {la, lb, walk}, {Y, R, 1'b0});

        // sb drops on the 2nd tick of B_GREEN: early release on that tick.
        apply_reset();
        run_phase("er_pre", 1, R, R, 1'b0);
        run_phase("er_ag", 5, G, R, 1'b0);
        run_phase("er_ay", 2, Y, R, 1'b0);
        run_phase("er_ar", 1, R, R, 1'b0);
        run_phase("er_bg", 1, R, G, 1'b0);
        sb = 1'b0;
        tick_latency("early_rel", {R, G, 1'b0}, {R, Y, 1'b0});

        // sb already 0 at the first B tick: no release while timer is 0.
        apply_reset();
        sb = 1'b1;
        run_phase("t0_pre", 1, R, R, 1'b0);
        run_phase("t0_ag", 5, G, R, 1'b0);
        run_phase("t0_ay", 2, Y, R, 1'b0);
        run_phase("t0_ar", 1, R, R, 1'b0);
        sb = 1'b0;
        do_tick();
        check("t0_no_rel", {la, lb, walk}, {R, G, 1'b0});
        do_tick();
        check("t1_rel", {la, lb, walk}, {R, Y, 1'b0});

        // Pedestrian request during A_GREEN.
        apply_reset();
        sb = 1'b1;
        run_phase("ped_pre", 1, R, R, 1'b0);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        run_phase("ped_ag", 5, G, R, 1'b0);
        run_phase("ped_ay", 2, Y, R, 1'b0);
        run_phase("ped_ar", 1, R, R, 1'b0);
`ifdef TL_PED_WALK_EN
        run_phase("ped_walk", 4, R, R, 1'b1);
`endif
        run_phase("ped_bg", 5, R, G, 1'b0);
        run_phase("ped_by", 2, R, Y, 1'b0);
        run_phase("ped_arb", 1, R, R, 1'b0);
        // Pending request was consumed: straight back to A.
        check("ped_cleared", {la, lb, walk}, {G, R, 1'b0});

        // Asynchronous reset in the middle of B_YELLOW.
        run_phase("ar_ag", 5, G, R, 1'b0);
        run_phase("ar_ay", 2, Y, R, 1'b0);
        run_phase("ar_ar", 1, R, R, 1'b0);
        run_phase("ar_bg", 5, R, G, 1'b0);
        do_tick();
        check("mid_b_yellow", {la, lb, walk}, {R, Y, 1'b0});
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_rst", {la, lb, walk}, {R, R, 1'b0});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb    = 1'b0;
        @(negedge clk);
        run_phase("rst_allred", 1, R, R, 1'b0);
        check("rst_a_green", {la, lb, walk}, {G, R, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
